alu_issue_ctrl: RTL
===================

# alu_issue_ctrl

Request front-end for the iterative ALU. Accepts operations over a valid/ready request channel and drives the ALU's operand and opcode ports. It sequences single-cycle (add/sub) and 34-cycle (mul/div) operations by watching the ALU's busy flag, then returns the 64-bit result with a tag over a valid/ready response channel. It is the ALU's only upstream driver and shields the ALU from stray opcodes while the ALU is idle.

## Interface
- TAG_W, 4: width of request/response tag.
- TIMEOUT, 40: maximum WAIT cycles with alu_busy=1 before an error response is issued.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when both high.
- req_op  in  3  000 add, 001 sub, 010 mul, 011 div; 100–111 illegal.
- req_a, req_b  in  32  operands.
- req_tag  in  TAG_W  returned unchanged with the response.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when both high.
- rsp_result  out  64  ALU result. Add/sub: {32'b0, sum}. Mul: signed product. Div: {remainder, quotient}.
- rsp_tag  out  TAG_W  tag of the request.
- rsp_err  out  1  illegal opcode or timeout.
- alu_operandA, alu_operandB  out  32  to ALU.
- alu_operation  out  3  to ALU; 3'b111 (NOP) whenever not issuing.
- alu_operation_valid  out  1  high only in ISSUE.
- alu_result  in  64  from ALU.
- alu_busy  in  1  from ALU.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready = !alu_busy.
  - On handshake, latch op, a, b and tag; a and b are loaded into the alu_operandA/B registers.
  - Legal op -> ISSUE.
  - Illegal op -> RESP with rsp_err=1 and rsp_result=0. The ALU is not touched.
- ISSUE (exactly 1 cycle): alu_operation=op and alu_operation_valid=1 -> WAIT.
- WAIT:
  - alu_operation=NOP.
  - alu_operandA/B are held stable from ISSUE until the next accept. The ALU reads operand A during division.
  - Add/sub: capture alu_result on the first WAIT cycle -> RESP.
  - Mul/div: the wait counter increments each cycle. When alu_busy=0, capture alu_result and go to RESP with rsp_err=0.
  - If the counter reaches TIMEOUT while alu_busy=1, go to RESP with rsp_err=1 and rsp_result=alu_result at that cycle.
- RESP:
  - rsp_valid=1. rsp_result, rsp_tag and rsp_err are stable until the handshake.
  - On rsp_ready -> IDLE.
  - req_ready=0 in RESP; no overlap between requests.
- alu_operation and alu_operation_valid are decoded from the registered state and op. There is no combinational path from any req_* input to any alu_* output.
- The ALU launches on any mul/div opcode seen while it is not busy, so NOP must be driven in every state except ISSUE.

## Timing
- Accept handshake at cycle T -> ISSUE at T+1.
- Add/sub: ALU registers its result at the end of T+1. Capture in WAIT at T+2; rsp_valid at T+3.
- Mul/div: alu_busy is high T+2..T+35 (34 cycles) and low at T+36. Capture at T+36; rsp_valid at T+37.
- Illegal op: rsp_valid at T+1.
- Throughput: one operation per latency + 1 cycles, minimum, with rsp_ready held high.
- Reset (rst=0 at a rising edge):
  - State IDLE; rsp_valid=0, rsp_result=0, rsp_tag=0, rsp_err=0.
  - alu_operandA/B=0, alu_operation=NOP, alu_operation_valid=0, wait counter=0.
- Reset mid-operation: the in-flight operation is discarded with no response. If the ALU is still busy after reset, req_ready stays 0 until alu_busy=0.
- req_valid deasserting without a handshake has no effect.
- rsp_ready high outside RESP is ignored.

## Structure
- Shared package alu_pkg holds:
  - Opcode constants ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_MUL=3'b010, ALU_DIV=3'b011, ALU_NOP=3'b111.
  - The issue-controller state enum.
  - MULDIV_BUSY_CYCLES=34.
- Single module, no sub-module. The wait counter is 6 bits and sized to cover TIMEOUT.

## Test plan
- Add, a=5, b=3, rsp_ready=1 -> rsp_valid at T+3, rsp_result=64'h0000_0000_0000_0008, rsp_err=0, tag echoed.
- Sub, a=3, b=5 -> rsp_result=64'h0000_0000_FFFF_FFFE at T+3; alu_operation=NOP in every cycle except T+1.
- Mul, a=7, b=32'hFFFF_FFFD -> alu_busy high exactly 34 cycles; rsp_valid at T+37; rsp_result=64'hFFFF_FFFF_FFFF_FFEB.
- Div, a=100, b=7 -> rsp_result=64'h0000_0002_0000_000E at T+37; alu_operandA/B stable throughout.
- Illegal op 3'b101 with tag 4'hA -> rsp_valid at T+1, rsp_err=1, rsp_result=0, rsp_tag=4'hA; alu_operation_valid never asserted.
- Backpressure and reset:
  - Hold rsp_ready=0 for 10 cycles after a mul -> response fields stable and req_ready=0 throughout.
  - Assert rst=0 at T+10 of a mul -> all outputs at reset values next cycle; no response for the aborted tag.
  - Force alu_busy=1 stuck -> rsp_err=1 after TIMEOUT WAIT cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU and its issue controller:
// opcode encodings, data widths, issue-controller state encoding and
// the fixed multi-cycle latency of mul/div.
package alu_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RES_W  = 64;

    localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [OP_W-1:0] ALU_MUL = 3'b010;
    localparam logic [OP_W-1:0] ALU_DIV = 3'b011;
    localparam logic [OP_W-1:0] ALU_NOP = 3'b111;

    // Cycles alu_busy stays high after a mul/div launch.
    localparam int unsigned MULDIV_BUSY_CYCLES = 34;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } issue_state_e;

    // Only add/sub/mul/div are accepted; 100..111 are rejected.
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_MUL) || (op == ALU_DIV);
    endfunction

    function automatic logic op_is_muldiv(input logic [OP_W-1:0] op);
        return (op == ALU_MUL) || (op == ALU_DIV);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Request front-end for the iterative ALU. Accepts one operation at a time
// over req_*, issues it to the ALU for exactly one cycle, waits for the
// result (immediately for add/sub, on alu_busy falling for mul/div, or a
// timeout), then returns result/tag/err over rsp_*.
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   req_valid/ready/op/a/b/tag     request channel
//   rsp_valid/ready/result/tag/err response channel
//   alu_operandA/B, alu_operation, alu_operation_valid   to ALU
//   alu_result, alu_busy                                 from ALU
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_result,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err,
    output logic [DATA_W-1:0] alu_operandA,
    output logic [DATA_W-1:0] alu_operandB,
    output logic [OP_W-1:0]   alu_operation,
    output logic              alu_operation_valid,
    input  logic [RES_W-1:0]  alu_result,
    input  logic              alu_busy
);

    localparam int unsigned CNT_W = 6;

    issue_state_e        state, state_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [CNT_W-1:0]    wait_cnt, wait_cnt_d, wait_inc;
    logic                rsp_valid_d, rsp_err_d;
    logic [RES_W-1:0]    rsp_result_d;
    logic [TAG_W-1:0]    rsp_tag_d;
    logic [DATA_W-1:0]   operand_a_d, operand_b_d;
    logic [OP_W-1:0]     alu_operation_d;
    logic                alu_operation_valid_d;
    logic                accept;

    // A new request is only taken while idle and the ALU has drained.
    assign req_ready = (state == ST_IDLE) && !alu_busy;
    assign accept    = req_valid && req_ready;
    assign wait_inc  = wait_cnt + CNT_W'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and next-register values.
    always_comb begin
        state_d               = state;
        op_d                  = op_q;
        wait_cnt_d            = wait_cnt;
        rsp_valid_d           = rsp_valid;
        rsp_err_d             = rsp_err;
        rsp_result_d          = rsp_result;
        rsp_tag_d             = rsp_tag;
        operand_a_d           = alu_operandA;
        operand_b_d           = alu_operandB;
        // NOP unless the next cycle is ISSUE, so the ALU never sees a stray launch.
        alu_operation_d       = ALU_NOP;
        alu_operation_valid_d = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    op_d        = req_op;
                    operand_a_d = req_a;
                    operand_b_d = req_b;
                    rsp_tag_d   = req_tag;
                    wait_cnt_d  = '0;
                    if (op_is_legal(req_op)) begin
                        alu_operation_d       = req_op;
                        alu_operation_valid_d = 1'b1;
                        state_d               = ST_ISSUE;
                    end else begin
                        rsp_result_d = '0;
                        rsp_err_d    = 1'b1;
                        rsp_valid_d  = 1'b1;
                        state_d      = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                wait_cnt_d = wait_inc;
                if (!op_is_muldiv(op_q) || !alu_busy) begin
                    rsp_result_d = alu_result;
                    rsp_err_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_RESP;
                end else if (wait_inc == CNT_W'(TIMEOUT)) begin
                    // ALU stuck busy: report whatever it currently shows.
                    rsp_result_d = alu_result;
                    rsp_err_d    = 1'b1;
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q                <= ALU_NOP;
            wait_cnt            <= '0;
            rsp_valid           <= 1'b0;
            rsp_err             <= 1'b0;
            rsp_result          <= '0;
            rsp_tag             <= '0;
            alu_operandA        <= '0;
            alu_operandB        <= '0;
            alu_operation       <= ALU_NOP;
            alu_operation_valid <= 1'b0;
        end else begin
            op_q                <= op_d;
            wait_cnt            <= wait_cnt_d;
            rsp_valid           <= rsp_valid_d;
            rsp_err             <= rsp_err_d;
            rsp_result          <= rsp_result_d;
            rsp_tag             <= rsp_tag_d;
            alu_operandA        <= operand_a_d;
            alu_operandB        <= operand_b_d;
            alu_operation       <= alu_operation_d;
            alu_operation_valid <= alu_operation_valid_d;
        end
    end

endmodule
